// File: rtl/fsm_prog.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_prog
//  Description : Run-time programmable Mealy state machine. A flop-based
//                transition/output table, indexed by {state, input}, is
//                loaded through a configuration write port. The machine
//                then steps through the table once per enabled clock.
//                Optional macro FSM_PROG_REG_OUT_EN registers the outputs
//                (one-cycle lag, no combinational in->out path).
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_prog #(
    parameter int NS     = 5,   // number of states, >= 2
    parameter int NI     = 2,   // number of control inputs
    parameter int NO     = 4,   // number of outputs
    parameter int RST_ST = 0    // state on reset and on an illegal transition
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NI-1:0]                 in,
    input  logic                          cfg_we,
    input  logic [$clog2(NS)+NI-1:0]      cfg_addr,
    input  logic [$clog2(NS)+NO-1:0]      cfg_data,
    output logic [$clog2(NS)-1:0]         st,
    output logic [NO-1:0]                 out,
    output logic                          err,
    output logic                          err_sticky
);

    localparam int SW = $clog2(NS);          // state index width
    localparam int AW = SW + NI;             // table address width
    localparam int EW = SW + NO;             // table entry width
    localparam int NE = NS * (1 << NI);      // number of table entries

    // Reset content of every entry: go to the reset state, outputs low.
    localparam logic [EW-1:0] c_ENTRY_RST = {SW'(RST_ST), {NO{1'b0}}};

    logic [EW-1:0] r_tbl [NE];
    logic [SW-1:0] r_st;
    logic          r_err;
    logic          r_err_sticky;

    logic [AW-1:0] w_idx;
    logic [EW-1:0] w_entry;
    logic [SW-1:0] w_ns;
    logic [NO-1:0] w_o;
    logic          w_ns_legal;
    logic          w_wr_ok;
    logic          w_step;

    // Current lookup address; the state field sits in the MSBs.
    assign w_idx = {r_st, in};

    // Table read mux; r_st never exceeds NS-1 so every legal index hits an entry.
    always_comb begin
        w_entry = c_ENTRY_RST;
        for (int k = 0; k < NE; k++) begin
            if (w_idx == AW'(k)) begin
                w_entry = r_tbl[k];
            end
        end
    end

    assign w_ns       = w_entry[EW-1:NO];
    assign w_o        = w_entry[NO-1:0];
    assign w_ns_legal = (int'(w_ns) < NS);

    // Writes whose state field names a non-existent state are discarded.
    assign w_wr_ok = cfg_we && (int'(cfg_addr[AW-1:NI]) < NS);

    // A configuration write always wins over stepping.
    assign w_step = en && !cfg_we;

    // One register per table entry, loaded when the write address matches.
    generate
        for (genvar k = 0; k < NE; k++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tbl[k] <= c_ENTRY_RST;
                end else if (w_wr_ok && (cfg_addr == AW'(k))) begin
                    r_tbl[k] <= cfg_data;
                end
            end
        end
    endgenerate

    // State advance with illegal-transition recovery and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st         <= SW'(RST_ST);
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else if (w_step) begin
            if (w_ns_legal) begin
                r_st  <= w_ns;
                r_err <= 1'b0;
            end else begin
                r_st         <= SW'(RST_ST);
                r_err        <= 1'b1;
                r_err_sticky <= 1'b1;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    assign st         = r_st;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;

`ifdef FSM_PROG_REG_OUT_EN
    logic [NO-1:0] r_out;

    // Registered outputs: sample the lookup every edge, independent of en/cfg_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_o;
        end
    end

    assign out = r_out;
`else
    // Pure Mealy outputs straight from the table lookup.
    assign out = w_o;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_prog
//  Description : Self-checking bench for fsm_prog (NS=5, NI=2, NO=4,
//                RST_ST=0). Directed vector table, reset and random phases
//                against a table-of-arrays reference model. Honours
//                FSM_PROG_REG_OUT_EN for the expected output timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] in;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [6:0] cfg_data;
    logic [2:0] st;
    logic [3:0] out;
    logic       err;
    logic       err_sticky;

    fsm_prog #(.NS(5), .NI(2), .NO(4), .RST_ST(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in         (in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .st         (st),
        .out        (out),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: next-state / output table as plain arrays
    int m_ns [5][4];
    int m_o  [5][4];
    int m_st, m_err, m_sticky, m_oreg;

    // Sampled DUT values and model expectations for one cycle
    int pre_out, exp_pre_out;
    int post_st, post_err, post_sticky, post_out;

    typedef struct {
        logic       e;
        logic       w;
        logic [4:0] a;
        logic [6:0] d;
        logic [1:0] i;
        int         x_out;     // lookup output before the edge
        int         x_st;      // state after the edge
        int         x_err;
        int         x_sticky;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 5; s++)
            for (int j = 0; j < 4; j++) begin
                m_ns[s][j] = 0;
                m_o[s][j]  = 0;
            end
        m_st = 0; m_err = 0; m_sticky = 0; m_oreg = 0;
    endtask

    // Drive one cycle starting at a negedge; sample before and after the posedge.
    task automatic drive_cycle(input logic e, input logic w, input logic [4:0] a,
                               input logic [6:0] d, input logic [1:0] i);
        int as, ai, nxt;
        en = e; cfg_we = w; cfg_addr = a; cfg_data = d; in = i;
        #1;
        pre_out     = int'(out);
        exp_pre_out = m_o[m_st][int'(i)];
        @(posedge clk);
        m_oreg = m_o[m_st][int'(i)];
        as = int'(a) / 4;
        ai = int'(a) % 4;
        if (w) begin
            if (as < 5) begin
                m_ns[as][ai] = int'(d) / 16;
                m_o[as][ai]  = int'(d) % 16;
            end
            m_err = 0;
        end else if (e) begin
            nxt = m_ns[m_st][int'(i)];
            if (nxt < 5) begin
                m_st = nxt; m_err = 0;
            end else begin
                m_st = 0; m_err = 1; m_sticky = 1;
            end
        end else begin
            m_err = 0;
        end
        #1;
        post_st = int'(st); post_err = int'(err);
        post_sticky = int'(err_sticky); post_out = int'(out);
        @(negedge clk);
    endtask

    initial begin
        // Directed vectors: {en, we, addr, data, in, out, st, err, sticky}
        vecs[0]  = '{1'b1, 1'b1, 5'b000_00, 7'b010_0010, 2'b00, 0, 0, 0, 0}; // load {0,00}
        vecs[1]  = '{1'b0, 1'b1, 5'b010_10, 7'b010_1000, 2'b00, 2, 0, 0, 0}; // load {2,10}
        vecs[2]  = '{1'b1, 1'b0, 5'b000_00, 7'b000_0000, 2'b00, 2, 2, 0, 0}; // step 0->2
        vecs[3]  = '{1'b1, 1'b0, 5'b000_00, 7'b000_0000, 2'b10, 8, 2, 0, 0}; // stay in 2
        vecs[4]  = '{1'b1, 1'b1, 5'b000_11, 7'b110_0000, 2'b10, 8, 2, 0, 0}; // we+en: hold
        vecs[5]  = '{1'b1, 1'b1, 5'b101_01, 7'b000_0101, 2'b10, 8, 2, 0, 0}; // state 5: dropped
        vecs[6]  = '{1'b1, 1'b1, 5'b111_00, 7'b000_1111, 2'b10, 8, 2, 0, 0}; // state 7: dropped
        vecs[7]  = '{1'b1, 1'b0, 5'b000_00, 7'b000_0000, 2'b00, 0, 0, 0, 0}; // {2,00} reset entry
        vecs[8]  = '{1'b1, 1'b0, 5'b000_00, 7'b000_0000, 2'b11, 0, 0, 1, 1}; // illegal ns=6
        vecs[9]  = '{1'b0, 1'b0, 5'b000_00, 7'b000_0000, 2'b00, 2, 0, 0, 1}; // hold
        vecs[10] = '{1'b0, 1'b0, 5'b000_00, 7'b000_0000, 2'b11, 0, 0, 0, 1}; // held illegal: no err
        vecs[11] = '{1'b0, 1'b0, 5'b000_00, 7'b000_0000, 2'b01, 0, 0, 0, 1}; // hold
        vecs[12] = '{1'b0, 1'b0, 5'b000_00, 7'b000_0000, 2'b10, 0, 0, 0, 1}; // hold

        rst = 1'b1; en = 1'b0; in = 2'b00; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        #1;
        chk("por_st", int'(st), 0);
        chk("por_out", int'(out), 0);
        chk("por_err", int'(err), 0);
        chk("por_sticky", int'(err_sticky), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int v = 0; v < 13; v++) begin
            drive_cycle(vecs[v].e, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].i);
`ifdef FSM_PROG_REG_OUT_EN
            chk($sformatf("vec%0d_out_reg", v), post_out, vecs[v].x_out);
`else
            chk($sformatf("vec%0d_out", v), pre_out, vecs[v].x_out);
`endif
            chk($sformatf("vec%0d_st", v), post_st, vecs[v].x_st);
            chk($sformatf("vec%0d_err", v), post_err, vecs[v].x_err);
            chk($sformatf("vec%0d_sticky", v), post_sticky, vecs[v].x_sticky);
        end

        // Asynchronous reset mid-run, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("rst_st", int'(st), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset table: stepping with any input stays in state 0, out 0
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b1, 1'b0, 5'd0, 7'd0, 2'(c));
            chk("rtbl_out", pre_out, 0);
            chk("rtbl_st", post_st, 0);
            chk("rtbl_out_post", post_out, 0);
        end

        // Randomised load/step traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic w, e;
            logic [4:0] a;
            logic [6:0] d;
            logic [1:0] i;
            w = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = 5'($urandom);
            d = 7'($urandom);
            // Bias next-state toward legal values so the machine moves around
            if ($urandom_range(0, 4) != 0) d[6:4] = 3'($urandom_range(0, 4));
            i = 2'($urandom);
            drive_cycle(e, w, a, d, i);
`ifdef FSM_PROG_REG_OUT_EN
            chk("rnd_out_reg", post_out, m_oreg);
`else
            chk("rnd_out", pre_out, exp_pre_out);
`endif
            chk("rnd_st", post_st, m_st);
            chk("rnd_err", post_err, m_err);
            chk("rnd_sticky", post_sticky, m_sticky);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
